// File: rtl/reg_scoreboard_if.sv
// Issue/writeback bundle between the ID stage and the register scoreboard.
interface reg_scoreboard_if;
    logic        issue_valid;
    logic        issue_wb_en;
    logic [3:0]  issue_dest;
    logic [3:0]  src_1;
    logic [3:0]  src_2;
    logic        two_src;
    logic        flush;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic        hazard;
    logic [15:0] busy_vector;
    logic        err_underflow;

    modport master (
        output issue_valid, issue_wb_en, issue_dest,
        output src_1, src_2, two_src, flush,
        output wb_en, wb_dest,
        input  hazard, busy_vector, err_underflow
    );

    modport slave (
        input  issue_valid, issue_wb_en, issue_dest,
        input  src_1, src_2, two_src, flush,
        input  wb_en, wb_dest,
        output hazard, busy_vector, err_underflow
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for R0-R14; stalls ID on RAW or counter saturation.
// Optional stall statistics counter enabled by HAZARD_STATS_EN.
module reg_scoreboard #(
    parameter int CNT_W  = 2,
    parameter int STAT_W = 16
) (
    input  logic clk,
    input  logic rst,
    reg_scoreboard_if.slave sb
`ifdef HAZARD_STATS_EN
    ,
    output logic [STAT_W-1:0] stall_count
`endif
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [3:0]       PC_REG  = 4'd15;

    // Entry 15 exists only so any 4-bit index is legal; it never leaves zero.
    logic [CNT_W-1:0] pending_q [16];
    logic [CNT_W-1:0] pending_d [16];
    logic             err_q, err_d;

    logic raw1, raw2, sat, hazard, accept, inc, dec, under;
    logic inc_hit, dec_hit;

    always_comb begin
        raw1   = (pending_q[sb.src_1] != '0);
        raw2   = sb.two_src && (pending_q[sb.src_2] != '0);
        sat    = sb.issue_wb_en && (sb.issue_dest != PC_REG)
                 && (pending_q[sb.issue_dest] == CNT_MAX);
        hazard = sb.issue_valid && (raw1 || raw2 || sat);
        accept = sb.issue_valid && !hazard && !sb.flush;
        inc    = accept && sb.issue_wb_en && (sb.issue_dest != PC_REG);
        dec    = sb.wb_en && (sb.wb_dest != PC_REG)
                 && (pending_q[sb.wb_dest] != '0);
        under  = sb.wb_en && (sb.wb_dest != PC_REG)
                 && (pending_q[sb.wb_dest] == '0);
    end

    always_comb begin
        pending_d = pending_q;
        inc_hit   = 1'b0;
        dec_hit   = 1'b0;
        for (int r = 0; r < 15; r++) begin
            inc_hit = inc && (sb.issue_dest == 4'(r));
            dec_hit = dec && (sb.wb_dest == 4'(r));
            if (inc_hit && !dec_hit)
                pending_d[r] = pending_q[r] + CNT_ONE;
            else if (dec_hit && !inc_hit)
                pending_d[r] = pending_q[r] - CNT_ONE;
        end
        pending_d[15] = '0;
        err_d = err_q || under;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 16; r++)
                pending_q[r] <= '0;
            err_q <= 1'b0;
        end else begin
            for (int r = 0; r < 16; r++)
                pending_q[r] <= pending_d[r];
            err_q <= err_d;
        end
    end

    always_comb begin
        sb.busy_vector = '0;
        for (int r = 0; r < 15; r++)
            sb.busy_vector[r] = (pending_q[r] != '0);
    end

    assign sb.hazard        = hazard;
    assign sb.err_underflow = err_q;

`ifdef HAZARD_STATS_EN
    localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

    logic [STAT_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (hazard && (stall_q != '1))
            stall_d = stall_q + STAT_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end

    assign stall_count = stall_q;
`endif
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard; inputs change on the falling edge.
module tb_reg_scoreboard;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    reg_scoreboard_if sb ();

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_count;
`endif

    reg_scoreboard #(.CNT_W(2), .STAT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb.slave)
`ifdef HAZARD_STATS_EN
        ,
        .stall_count (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [3:0] d,
                         input logic [3:0] s1, input logic [3:0] s2,
                         input logic two, input logic fl,
                         input logic wbe, input logic [3:0] wbd);
        @(negedge clk);
        sb.issue_valid = v;
        sb.issue_wb_en = we;
        sb.issue_dest  = d;
        sb.src_1       = s1;
        sb.src_2       = s2;
        sb.two_src     = two;
        sb.flush       = fl;
        sb.wb_en       = wbe;
        sb.wb_dest     = wbd;
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        sb.issue_valid = 0; sb.issue_wb_en = 0; sb.issue_dest = 0;
        sb.src_1 = 0; sb.src_2 = 0; sb.two_src = 0; sb.flush = 0;
        sb.wb_en = 0; sb.wb_dest = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_hazard", 32'(sb.hazard), 0);
        chk("rst_busy", 32'(sb.busy_vector), 0);
        chk("rst_err", 32'(sb.err_underflow), 0);
`ifdef HAZARD_STATS_EN
        chk("rst_stall", 32'(stall_count), 0);
`endif
        @(negedge clk) rst = 1'b0;

        // dependent pair: ADD R1 then ADD R2 reading R1
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0);
        chk("s1_prod_hz", 32'(sb.hazard), 0);
        drive(1, 1, 2, 1, 0, 0, 0, 0, 0);
        chk("s1_exe_hz", 32'(sb.hazard), 1);
        chk("s1_busy", 32'(sb.busy_vector), 32'h0002);
        drive(1, 1, 2, 1, 0, 0, 0, 0, 0);
        chk("s1_mem_hz", 32'(sb.hazard), 1);
        drive(1, 1, 2, 1, 0, 0, 0, 1, 1);
        chk("s1_wb_hz", 32'(sb.hazard), 1);
        drive(1, 1, 2, 1, 0, 0, 0, 0, 0);
        chk("s1_issue_hz", 32'(sb.hazard), 0);
        chk("s1_busy_clr", 32'(sb.busy_vector), 32'h0000);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 2);
        chk("s1_r2_busy", 32'(sb.busy_vector), 32'h0004);
`ifdef HAZARD_STATS_EN
        chk("s1_stalls", 32'(stall_count), 3);
`endif
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("s1_idle_busy", 32'(sb.busy_vector), 0);

        // saturate R3 at three in-flight writes
        drive(1, 1, 3, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 3, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 3, 0, 0, 0, 0, 0, 0);
        chk("s2_third_hz", 32'(sb.hazard), 0);
        drive(1, 1, 3, 0, 0, 0, 0, 0, 0);
        chk("s2_sat_hz", 32'(sb.hazard), 1);
        chk("s2_busy", 32'(sb.busy_vector), 32'h0008);
        drive(1, 1, 3, 0, 0, 0, 0, 1, 3);
        chk("s2_sat_wb_hz", 32'(sb.hazard), 1);
        drive(1, 1, 3, 0, 0, 0, 0, 0, 0);
        chk("s2_fourth_hz", 32'(sb.hazard), 0);
        drive(1, 1, 3, 0, 0, 0, 0, 0, 0);
        chk("s2_resat_hz", 32'(sb.hazard), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 3);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 3);
        chk("s2_drain_busy", 32'(sb.busy_vector), 32'h0008);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 3);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("s2_empty", 32'(sb.busy_vector), 0);
        chk("s2_no_under", 32'(sb.err_underflow), 0);

        // simultaneous increment/decrement
        drive(1, 1, 5, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 5, 0, 0, 0, 0, 1, 5);
        chk("s3_same_hz", 32'(sb.hazard), 0);
        chk("s3_busy5", 32'(sb.busy_vector), 32'h0020);
        drive(1, 1, 7, 0, 0, 0, 0, 1, 5);
        chk("s3_same_keep", 32'(sb.busy_vector), 32'h0020);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("s3_diff_regs", 32'(sb.busy_vector), 32'h0080);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 7);

        // flush and R15 sources
        drive(1, 1, 4, 0, 0, 0, 1, 0, 0);
        chk("s4_flush_hz", 32'(sb.hazard), 0);
        chk("s4_pre_busy", 32'(sb.busy_vector), 0);
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0);
        chk("s4_flush_r4", 32'(sb.busy_vector), 0);
        drive(1, 0, 8, 15, 15, 1, 0, 0, 0);
        chk("s4_pc_src_hz", 32'(sb.hazard), 0);
        chk("s4_r1_busy", 32'(sb.busy_vector), 32'h0002);
        drive(1, 0, 8, 0, 1, 0, 0, 0, 0);
        chk("s4_one_src_hz", 32'(sb.hazard), 0);
        drive(1, 0, 8, 0, 1, 1, 0, 0, 0);
        chk("s4_raw2_hz", 32'(sb.hazard), 1);
        drive(1, 0, 8, 1, 0, 0, 1, 0, 0);
        chk("s4_flush_raw_hz", 32'(sb.hazard), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);

        // underflow, then asynchronous reset mid-stall
        drive(0, 0, 0, 0, 0, 0, 0, 1, 6);
        chk("s5_pre_err", 32'(sb.err_underflow), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("s5_err_set", 32'(sb.err_underflow), 1);
        chk("s5_under_cnt", 32'(sb.busy_vector), 0);
        drive(1, 1, 9, 0, 0, 0, 0, 0, 0);
        chk("s5_err_sticky", 32'(sb.err_underflow), 1);
        drive(1, 0, 0, 9, 0, 0, 0, 0, 0);
        chk("s5_stall_hz", 32'(sb.hazard), 1);
        #2 rst = 1'b1;
        #1;
        chk("s5_rst_hz", 32'(sb.hazard), 0);
        chk("s5_rst_busy", 32'(sb.busy_vector), 0);
        chk("s5_rst_err", 32'(sb.err_underflow), 0);
`ifdef HAZARD_STATS_EN
        chk("s5_rst_stall", 32'(stall_count), 0);
`endif
        @(negedge clk) rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 1, 9);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("s5_late_wb_err", 32'(sb.err_underflow), 1);
        chk("s5_late_busy", 32'(sb.busy_vector), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register-file hazard controller for the ARM pipeline, sitting beside the ID stage. It keeps a pending-write counter for each general register (R0–R14). It uses these counts to stall issue from ID while an in-flight instruction in EXE/MEM/WB still owes a write to a source register of the decoding instruction. It replaces per-stage destination comparison with a scoreboard, so it is independent of pipeline depth.

## Interface
Parameters:
- CNT_W, 2, width of each pending counter; max in-flight writes per register = 2^CNT_W − 1.
- STAT_W, 16, width of the stall counter (used only with HAZARD_STATS_EN).

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- issue_valid  input  1  ID holds a decoded instruction this cycle.
- issue_wb_en  input  1  that instruction writes the register file.
- issue_dest  input  4  destination register (instruction[15:12]).
- src_1  input  4  first source, Rn.
- src_2  input  4  second source: Rd for stores, Rm otherwise.
- two_src  input  1  src_2 is actually read.
- flush  input  1  branch taken in EXE; the ID instruction is squashed.
- wb_en  input  1  WB stage writes the register file this cycle.
- wb_dest  input  4  WB destination register.
- hazard  output  1  stall IF/ID and insert a bubble into EXE.
- busy_vector  output  16  bit r = (pending[r] != 0); bit 15 is always 0.
- err_underflow  output  1  sticky: a writeback arrived for a register with pending = 0.
- stall_count  output  STAT_W  cycles with hazard=1 (HAZARD_STATS_EN only).

## Operation
- State: pending[0..14], each CNT_W bits, plus err_underflow, plus stall_count when enabled.
- R15 (PC) is never tracked:
  - issue_dest = 15 does not increment.
  - wb_dest = 15 does not decrement.
  - src = 15 never raises a hazard.
- hazard is combinational: issue_valid & (raw1 | raw2 | sat).
  - raw1 = pending[src_1] != 0.
  - raw2 = two_src & pending[src_2] != 0.
  - sat = issue_wb_en & pending[issue_dest] == max.
- accept = issue_valid & ~hazard & ~flush.
- Increment: pending[issue_dest] += 1 when accept & issue_wb_en & issue_dest != 15.
- Decrement: pending[wb_dest] −= 1 when wb_en & wb_dest != 15 & pending[wb_dest] != 0.
- Underflow: wb_en with pending[wb_dest] = 0 (dest ≠ 15) leaves the count at 0 and sets err_underflow. The flag is cleared only by rst.
- Increment and decrement on the same register in the same cycle: the count is unchanged.
- Increment and decrement on different registers in the same cycle: both apply.
- flush suppresses the increment only; pending writes already in flight still retire through WB.
- hazard does not depend on flush. The pipeline's flush path overrides the stall.

## Timing
- Reset (asynchronous, immediate):
  - all pending = 0.
  - busy_vector = 0, err_underflow = 0, stall_count = 0.
  - hazard = 0 (issue_valid permitting).
- Counter updates on the rising edge following accept or wb_en. busy_vector is registered-state derived, with zero extra latency.
- Writeback-to-read: when the producer is in WB in cycle N, pending is still nonzero in N, so hazard = 1 in N. hazard drops in N+1 and the consumer issues in N+1 (no WB→ID bypass is assumed).
- Back-to-back dependent pair, no forwarding: the consumer stalls 3 cycles (EXE, MEM, WB of the producer).
- rst asserted mid-stall drops all state immediately. Any in-flight writebacks arriving after reset are treated as underflow and flag err_underflow.

## Configuration
- HAZARD_STATS_EN defined:
  - stall_count increments each cycle hazard = 1 and saturates at all-ones.
  - Reset value is 0.
- HAZARD_STATS_EN undefined:
  - the stall_count port and its logic are removed.
  - all other behaviour is identical.

## Test plan
- Reset, then issue ADD R1 (dest 1, wb_en), then issue ADD R2 with src_1 = 1 → hazard = 1 for 3 cycles. It drops the cycle after wb_en/wb_dest = 1, and busy_vector returns to 0x0000.
- Issue writes to R3 three times (CNT_W = 2) with no WB, then a 4th write to R3 → hazard = 1 via sat and pending[3] stays 3. After one wb_dest = 3, the 4th write is accepted.
- Same cycle: accepted issue to R5 and wb_en to R5 with pending[5] = 1 → pending[5] stays 1 and busy_vector[5] = 1.
- flush = 1 with a valid issue to R4 → pending[4] stays 0. A src_1 = 15 issue never stalls, even while busy_vector is nonzero.
- wb_en with wb_dest = 6 and pending[6] = 0 → err_underflow = 1 and it stays set. Asserting rst asynchronously mid-stall clears hazard, busy_vector, the flag, and stall_count at once.
- With HAZARD_STATS_EN: after the first scenario, stall_count = 3.
